// File: rtl/mem_stage_if.sv
// Bus between the EX/MEM pipeline register and the memory-access stage.
// Carries the access request, branch resolution inputs and the debug read port.
interface mem_stage_if #(
  parameter int NB           = 32,
  parameter int NB_SIZE_TYPE = 3,
  parameter int NB_ADDR      = 5
);
  logic                    i_step;
  logic [NB-1:0]           i_alu_result;
  logic [NB-1:0]           i_data_b;
  logic                    i_mem_read;
  logic                    i_mem_write;
  logic                    i_signed;
  logic [NB_SIZE_TYPE-1:0] i_word_size;
  logic                    i_cero;
  logic                    i_branch;
  logic [NB-1:0]           i_branch_addr;
  logic [NB_ADDR-1:0]      i_debug_addr;
  logic [NB-1:0]           o_read_data;
  logic                    o_pc_src;
  logic [NB-1:0]           o_branch_addr;
  logic                    o_misaligned;
  logic [NB-1:0]           o_debug_data;

  modport master (
    output i_step, i_alu_result, i_data_b, i_mem_read, i_mem_write, i_signed,
           i_word_size, i_cero, i_branch, i_branch_addr, i_debug_addr,
    input  o_read_data, o_pc_src, o_branch_addr, o_misaligned, o_debug_data
  );

  modport slave (
    input  i_step, i_alu_result, i_data_b, i_mem_read, i_mem_write, i_signed,
           i_word_size, i_cero, i_branch, i_branch_addr, i_debug_addr,
    output o_read_data, o_pc_src, o_branch_addr, o_misaligned, o_debug_data
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: little-endian byte-addressable data memory with
// sized loads/stores, branch resolution and a raw debug read port.
module mem_stage #(
  parameter int NB           = 32,
  parameter int NB_SIZE_TYPE = 3,
  parameter int NB_ADDR      = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  mem_stage_if.slave  bus
);
  localparam int DEPTH = 2 ** NB_ADDR;
  localparam logic [NB_SIZE_TYPE-1:0] SIZE_BYTE = NB_SIZE_TYPE'(1);
  localparam logic [NB_SIZE_TYPE-1:0] SIZE_HALF = NB_SIZE_TYPE'(2);

  logic [NB-1:0]      mem_r [DEPTH];
  logic [NB_ADDR-1:0] word_idx_s;
  logic [1:0]         lane_s;
  logic               is_byte_s;
  logic               is_half_s;
  logic               is_word_s;
  logic               misaligned_s;
  logic               wr_en_s;
  logic [NB-1:0]      cur_word_s;
  logic [NB-1:0]      wr_word_s;
  logic [7:0]         rd_byte_s;
  logic [15:0]        rd_half_s;
  logic [NB-1:0]      rd_data_s;
  logic               unused_addr_s;

  // Upper address bits are dropped so addresses wrap around the memory.
  assign word_idx_s    = bus.i_alu_result[NB_ADDR+1:2];
  assign lane_s        = bus.i_alu_result[1:0];
  assign unused_addr_s = ^bus.i_alu_result[NB-1:NB_ADDR+2];
  assign cur_word_s    = mem_r[word_idx_s];

  // Size decode and alignment check; unknown size codes behave as word.
  always_comb begin
    is_byte_s    = (bus.i_word_size == SIZE_BYTE);
    is_half_s    = (bus.i_word_size == SIZE_HALF);
    is_word_s    = !(is_byte_s || is_half_s);
    misaligned_s = (bus.i_mem_read || bus.i_mem_write) &&
                   ((is_half_s && lane_s[0]) || (is_word_s && (lane_s != 2'b00)));
    wr_en_s      = bus.i_step && bus.i_mem_write && !misaligned_s;
  end

  // Merge store data into the addressed word, keeping unselected lanes.
  always_comb begin
    wr_word_s = cur_word_s;
    if (is_byte_s) begin
      case (lane_s)
        2'd0:    wr_word_s[7:0]   = bus.i_data_b[7:0];
        2'd1:    wr_word_s[15:8]  = bus.i_data_b[7:0];
        2'd2:    wr_word_s[23:16] = bus.i_data_b[7:0];
        2'd3:    wr_word_s[31:24] = bus.i_data_b[7:0];
        default: wr_word_s        = cur_word_s;
      endcase
    end else if (is_half_s) begin
      if (lane_s[1]) begin
        wr_word_s[31:16] = bus.i_data_b[15:0];
      end else begin
        wr_word_s[15:0]  = bus.i_data_b[15:0];
      end
    end else begin
      wr_word_s = bus.i_data_b;
    end
  end

  // Combinational load path with sign/zero extension.
  always_comb begin
    case (lane_s)
      2'd0:    rd_byte_s = cur_word_s[7:0];
      2'd1:    rd_byte_s = cur_word_s[15:8];
      2'd2:    rd_byte_s = cur_word_s[23:16];
      2'd3:    rd_byte_s = cur_word_s[31:24];
      default: rd_byte_s = 8'h00;
    endcase
    rd_half_s = lane_s[1] ? cur_word_s[31:16] : cur_word_s[15:0];
    rd_data_s = '0;
    if (!bus.i_mem_read || misaligned_s) begin
      rd_data_s = '0;
    end else if (is_byte_s) begin
      rd_data_s = {{(NB-8){bus.i_signed & rd_byte_s[7]}}, rd_byte_s};
    end else if (is_half_s) begin
      rd_data_s = {{(NB-16){bus.i_signed & rd_half_s[15]}}, rd_half_s};
    end else begin
      rd_data_s = cur_word_s;
    end
  end

  // Memory array: reset clears every word and wins over a same-edge store.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[word_idx_s] <= wr_word_s;
    end
  end

  assign bus.o_read_data   = rd_data_s;
  assign bus.o_misaligned  = misaligned_s;
  assign bus.o_debug_data  = mem_r[bus.i_debug_addr];
  assign bus.o_pc_src      = bus.i_branch & bus.i_cero;
  assign bus.o_branch_addr = bus.i_branch_addr;
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined MIPS core. It sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. It holds the byte-addressable data memory and performs sized, optionally sign-extended loads and sized stores. It also resolves the branch decision and gives the debug unit a read port into data memory.

## Interface
Parameters:
- NB, 32: data/address width.
- NB_SIZE_TYPE, 3: width of the access-size code.
- NB_ADDR, 5: word-index width; memory depth is 2^NB_ADDR words.

Ports:
- i_clk  in  1  clock; one clock, memory updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_step  in  1  pipeline advance enable; stores commit only when high.
- i_alu_result  in  NB  byte address of the access.
- i_data_b  in  NB  store data; the low bytes are used for sub-word stores.
- i_mem_read  in  1  load request.
- i_mem_write  in  1  store request.
- i_signed  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- i_word_size  in  NB_SIZE_TYPE  access size code: 3'b001 byte, 3'b010 halfword, 3'b100 word; any other code is treated as word.
- i_cero  in  1  ALU zero flag.
- i_branch  in  1  branch instruction flag.
- i_branch_addr  in  NB  branch target.
- i_debug_addr  in  NB_ADDR  word index for the debug read.
- o_read_data  out  NB  load result, already extended.
- o_pc_src  out  1  i_branch & i_cero.
- o_branch_addr  out  NB  i_branch_addr, passed through.
- o_misaligned  out  1  current access is misaligned.
- o_debug_data  out  NB  raw memory word at i_debug_addr.

## Operation
- Word index = i_alu_result[NB_ADDR+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·2^NB_ADDR bytes.
- Byte lane = i_alu_result[1:0]. Memory is little-endian: lane 0 is bits [7:0].
- Misalignment rules:
  - Halfword access with lane[0]=1 is misaligned.
  - Word access with lane≠0 is misaligned.
  - o_misaligned is asserted only while i_mem_read or i_mem_write is high.
- Store: on the rising edge with i_step & i_mem_write & !o_misaligned & !i_reset.
  - Byte: writes i_data_b[7:0] into the selected lane.
  - Halfword: writes i_data_b[15:0] into lanes {1,0} or {3,2}.
  - Word: writes all 32 bits.
  - Unselected lanes keep their value.
  - A misaligned store is dropped and memory is unchanged.
- Load is combinational from the array.
  - Byte: selected byte, extended per i_signed.
  - Halfword: selected halfword, extended per i_signed.
  - Word: the full word; i_signed is ignored.
  - If i_mem_read=0 or the access is misaligned, o_read_data = 0.
- If i_mem_read and i_mem_write are both high, the store happens on the edge and o_read_data shows the pre-edge contents until the edge.
- o_debug_data is the raw word, independent of i_step and every other input.
- o_pc_src and o_branch_addr are combinational; i_step has no effect on them.

## Timing
- Reset: on a rising edge with i_reset=1, every memory word becomes 0. Reset has priority over a simultaneous store.
  - After reset: o_read_data=0, o_debug_data=0, o_misaligned=0.
  - o_pc_src and o_branch_addr follow their inputs even during reset, which is 0 while EX/MEM is held in reset.
- A reset in the middle of a program clears memory; there is no partial-write state.
- Inputs change on the falling edge (EX/MEM register). Stores sample them on the following rising edge, half a cycle later.
- Load latency is 0 cycles, combinational.
- A store is visible to loads and to the debug port immediately after its rising edge.
- With i_step=0, memory is frozen. Combinational outputs still track the inputs.

## Test plan
- Reset, then debug-read every index → all 0. Also: assert a store together with i_reset → memory stays 0.
- Word store 0xDEADBEEF at address 0x8 with step=1, then word load at 0x8 → 0xDEADBEEF; o_debug_data at index 2 → 0xDEADBEEF.
- Byte stores and loads at 0x8:
  - Store 0x80 to 0x9 → word reads 0xDEAD80EF.
  - Byte load 0x9, signed → 0xFFFFFF80; unsigned → 0x00000080.
  - Halfword load 0xA, signed → 0xFFFFDEAD.
- Misaligned halfword store at 0x3 and word load at 0x6 → o_misaligned=1, memory unchanged, o_read_data=0.
- Store with i_step=0 → no change. Address 0x88 with NB_ADDR=5 wraps to index 2.
- Branch resolution:
  - i_branch=1, i_cero=1, target 0x40 → o_pc_src=1, o_branch_addr=0x40.
  - i_cero=0 → o_pc_src=0.
